core_run_ctrl: RTL and testbench

//  Execution controller for the castor32rv single-cycle core. Gates the core's clock enable and sequences it:

---
 rtl/core_run_ctrl_pkg.sv | 34 +++
 rtl/core_run_ctrl_if.sv | 23 ++
 rtl/core_run_ctrl_bp_match.sv | 56 +++++
 rtl/core_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_core_run_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the castor32rv run/step/halt controller: command opcodes,
// halt causes and controller states.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_HALT    = 3'd1,
    OP_RUN     = 3'd2,
    OP_STEP    = 3'd3,
    OP_SET_BP  = 3'd4,
    OP_CLR_BP  = 3'd5,
    OP_CLR_CNT = 3'd6,
    OP_ILLEGAL = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_CMD   = 2'd1,
    CAUSE_STEP  = 2'd2,
    CAUSE_BP    = 2'd3
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } ctrl_state_e;

  // A single breakpoint slot still needs a one-bit index field.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Host/debug command channel into the run controller.
interface core_run_ctrl_if #(
  parameter int CNT_WIDTH = 32,
  parameter int IDX_WIDTH = 1
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [IDX_WIDTH-1:0] cmd_idx;
  logic [CNT_WIDTH-1:0] cmd_arg;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_arg,
    output cmd_ready
  );

endinterface

// File: rtl/core_run_ctrl_bp_match.sv
// PC breakpoint slots: per-slot address/enable registers compared in parallel
// against the live PC. Writes land at the clock edge, so a same-cycle match sees the old address.
module bp_match
  import core_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BP     = 2,
  localparam int IDX_WIDTH = idx_width(NUM_BP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic                  clr_en,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  hit,
  output logic [IDX_WIDTH-1:0]  hit_idx
);

  logic [ADDR_WIDTH-1:0] bp_addr [NUM_BP];
  logic [NUM_BP-1:0]     bp_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_en[i]   <= 1'b0;
        bp_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (idx == IDX_WIDTH'(i)) begin
          if (set_en) begin
            bp_en[i]   <= 1'b1;
            bp_addr[i] <= set_addr;
          end else if (clr_en) begin
            bp_en[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Scan from the top so the lowest matching slot is reported.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i] == pc_addr)) begin
        hit     = 1'b1;
        hit_idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/halt engine for the castor32rv core: gates core_en, stops on PC
// breakpoints, counts executed cycles and decodes host commands.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int NUM_BP     = 2,
  localparam int IDX_WIDTH = idx_width(NUM_BP)
) (
  input  logic                  clk,
  input  logic                  rst,
  core_run_ctrl_if.slave        cmd,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  core_en,
  output logic                  halted,
  output halt_cause_e           halt_cause,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  cmd_err,
  output logic [IDX_WIDTH-1:0]  bp_hit_idx
);

  ctrl_state_e          state, state_d;
  halt_cause_e          cause_d;
  logic [CNT_WIDTH-1:0] steps_left, steps_d;
  logic                 skip_bp, skip_d;
  logic                 err_d, set_en, clr_en, clr_cnt;
  logic                 hit, bp_hit, idx_bad;
  cmd_op_e              op;

  assign op            = cmd_op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = !rst;
  assign idx_bad       = (32'(cmd.cmd_idx) >= NUM_BP);
  assign bp_hit        = hit && !skip_bp;
  assign core_en       = (state != ST_HALTED) && !bp_hit;
  assign halted        = (state == ST_HALTED);

  bp_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BP     (NUM_BP)
  ) u_bp_match (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .clr_en   (clr_en),
    .idx      (cmd.cmd_idx),
    .set_addr (cmd.cmd_arg[ADDR_WIDTH-1:0]),
    .pc_addr  (pc_addr),
    .hit      (hit),
    .hit_idx  (bp_hit_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HALTED;
      halt_cause  <= CAUSE_RESET;
      steps_left  <= '0;
      skip_bp     <= 1'b0;
      cmd_err     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state      <= state_d;
      halt_cause <= cause_d;
      steps_left <= steps_d;
      skip_bp    <= skip_d;
      cmd_err    <= err_d;
      if (clr_cnt)
        cycle_count <= '0;
      else if (core_en)
        cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
  end

  // Execution events first; a breakpoint outranks step completion, and host commands are applied last.
  always_comb begin
    state_d = state;
    cause_d = halt_cause;
    steps_d = steps_left;
    skip_d  = skip_bp;
    err_d   = 1'b0;
    set_en  = 1'b0;
    clr_en  = 1'b0;
    clr_cnt = 1'b0;

    if (core_en) begin
      skip_d = 1'b0;
      if (state == ST_STEPPING) begin
        steps_d = steps_left - CNT_WIDTH'(1);
        if (steps_left == CNT_WIDTH'(1)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_STEP;
        end
      end
    end
    if ((state != ST_HALTED) && bp_hit) begin
      state_d = ST_HALTED;
      cause_d = CAUSE_BP;
      steps_d = '0;
    end

    if (cmd.cmd_valid) begin
      case (op)
        OP_NOP: ;
        OP_HALT: begin
          if (state != ST_HALTED) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_CMD;
            steps_d = '0;
          end
        end
        OP_RUN: begin
          if (state == ST_HALTED) begin
            state_d = ST_RUNNING;
            skip_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_STEP: begin
          if (state == ST_HALTED) begin
            state_d = ST_STEPPING;
            skip_d  = 1'b1;
            steps_d = (cmd.cmd_arg == '0) ? CNT_WIDTH'(1) : cmd.cmd_arg;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_SET_BP: begin
          if (idx_bad) err_d = 1'b1;
          else         set_en = 1'b1;
        end
        OP_CLR_BP: begin
          if (idx_bad) err_d = 1'b1;
          else         clr_en = 1'b1;
        end
        OP_CLR_CNT: clr_cnt = 1'b1;
        default:    err_d = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: stimulus queues expected halt/error events,
// a negedge monitor pops and compares them as the controller reports them.
module tb_core_run_ctrl;
  import core_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int CW = 8;
  localparam int NB = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc;
  logic          core_en, halted, cmd_err;
  logic [1:0]    halt_cause;
  logic [CW-1:0] cycle_count;
  logic [IW-1:0] bp_hit_idx;

  core_run_ctrl_if #(.CNT_WIDTH(CW), .IDX_WIDTH(IW)) cmd_bus ();

  core_run_ctrl #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW),
    .NUM_BP     (NB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_bus.slave),
    .pc_addr     (pc),
    .core_en     (core_en),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count),
    .cmd_err     (cmd_err),
    .bp_hit_idx  (bp_hit_idx)
  );

  always #5 clk = ~clk;

  // Stand-in core: PC advances one instruction per enabled cycle.
  always @(posedge clk) begin
    if (rst)          pc <= '0;
    else if (core_en) pc <= pc + 8'd4;
  end

  typedef struct {
    bit            is_err;
    logic [1:0]    cause;
    logic [CW-1:0] count;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic prev_halted = 1'b1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_halt(input logic [1:0] cause, input logic [CW-1:0] count, input logic [AW-1:0] pcv);
    exp_t e;
    e.is_err = 1'b0;
    e.cause  = cause;
    e.count  = count;
    e.pc     = pcv;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.cause  = '0;
    e.count  = '0;
    e.pc     = '0;
    sb.push_back(e);
  endtask

  // Called at a negedge; the command is taken at the following posedge.
  task automatic apply_stimulus(input cmd_op_e op, input logic [IW-1:0] idx, input logic [CW-1:0] arg);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_idx   = idx;
    cmd_bus.cmd_arg   = arg;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = OP_NOP;
    cmd_bus.cmd_idx   = '0;
    cmd_bus.cmd_arg   = '0;
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("halt_within_budget", {31'd0, halted}, 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (halted === 1'b1 && prev_halted !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_halt: got halt cause=%0d count=%0d, expected no event", halt_cause, cycle_count);
        end else begin
          e = sb.pop_front();
          check_output("event_kind_halt", 32'd0, {31'd0, e.is_err});
          check_output("halt_cause", {30'd0, halt_cause}, {30'd0, e.cause});
          check_output("halt_count", {24'd0, cycle_count}, {24'd0, e.count});
          check_output("halt_pc", {24'd0, pc}, {24'd0, e.pc});
        end
      end
      if (cmd_err === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_cmd_err: got pulse, expected no event");
        end else begin
          e = sb.pop_front();
          check_output("event_kind_err", 32'd1, {31'd0, e.is_err});
        end
      end
    end
    prev_halted = halted;
  end

  initial begin
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = OP_NOP;
    cmd_bus.cmd_idx   = '0;
    cmd_bus.cmd_arg   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_halted", {31'd0, halted}, 32'd1);
    check_output("reset_cause", {30'd0, halt_cause}, 32'd0);
    check_output("reset_core_en", {31'd0, core_en}, 32'd0);
    check_output("reset_count", {24'd0, cycle_count}, 32'd0);
    check_output("reset_cmd_err", {31'd0, cmd_err}, 32'd0);
    check_output("reset_cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_output("cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);

    // Free run for ten cycles, then halt by command.
    push_halt(CAUSE_CMD, 8'd10, 8'h28);
    apply_stimulus(OP_RUN, '0, '0);
    check_output("run_core_en", {31'd0, core_en}, 32'd1);
    repeat (9) @(negedge clk);
    apply_stimulus(OP_HALT, '0, '0);
    wait_halted(20);

    // Stepping: three steps, then arg 0 means one step.
    apply_stimulus(OP_CLR_CNT, '0, '0);
    check_output("clr_count", {24'd0, cycle_count}, 32'd0);
    push_halt(CAUSE_STEP, 8'd3, 8'h34);
    apply_stimulus(OP_STEP, '0, 8'd3);
    wait_halted(20);
    push_halt(CAUSE_STEP, 8'd4, 8'h38);
    apply_stimulus(OP_STEP, '0, 8'd0);
    wait_halted(20);

    // Breakpoint at 0x10 from a fresh PC, then resume past it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rereset_cause", {30'd0, halt_cause}, 32'd0);
    apply_stimulus(OP_SET_BP, 2'd0, 8'h10);
    push_halt(CAUSE_BP, 8'd4, 8'h10);
    apply_stimulus(OP_RUN, '0, '0);
    wait_halted(30);
    check_output("bp_core_en", {31'd0, core_en}, 32'd0);
    check_output("bp_hit_idx", {30'd0, bp_hit_idx}, 32'd0);
    push_halt(CAUSE_CMD, 8'd9, 8'h24);
    apply_stimulus(OP_RUN, '0, '0);
    repeat (4) @(negedge clk);
    apply_stimulus(OP_HALT, '0, '0);
    wait_halted(20);

    // Rejected commands while running; the out-of-range slot must not arm 0x30.
    apply_stimulus(OP_RUN, '0, '0);
    push_err();
    apply_stimulus(OP_RUN, '0, '0);
    push_err();
    apply_stimulus(OP_ILLEGAL, '0, '0);
    push_err();
    apply_stimulus(OP_SET_BP, 2'd3, 8'h30);
    push_halt(CAUSE_CMD, 8'd13, 8'h34);
    apply_stimulus(OP_HALT, '0, '0);
    wait_halted(20);

    // Clear wins over a same-cycle increment.
    apply_stimulus(OP_RUN, '0, '0);
    apply_stimulus(OP_CLR_CNT, '0, '0);
    check_output("clr_vs_inc", {24'd0, cycle_count}, 32'd0);
    push_halt(CAUSE_CMD, 8'd1, 8'h3C);
    apply_stimulus(OP_HALT, '0, '0);
    wait_halted(20);

    // Counter wrap; slot 0 cleared so the PC sweeps past 0x10 freely.
    apply_stimulus(OP_CLR_BP, 2'd0, '0);
    apply_stimulus(OP_CLR_CNT, '0, '0);
    push_halt(CAUSE_STEP, 8'hFF, 8'h38);
    apply_stimulus(OP_STEP, '0, 8'd255);
    wait_halted(400);
    push_halt(CAUSE_STEP, 8'h00, 8'h3C);
    apply_stimulus(OP_STEP, '0, 8'd1);
    wait_halted(20);

    // Reset mid-step with five steps left, then confirm slot 1 was wiped.
    apply_stimulus(OP_SET_BP, 2'd1, 8'h80);
    apply_stimulus(OP_STEP, '0, 8'd8);
    repeat (3) @(negedge clk);
    push_halt(CAUSE_RESET, 8'd0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check_output("midstep_rst_halted", {31'd0, halted}, 32'd1);
    check_output("midstep_rst_core_en", {31'd0, core_en}, 32'd0);
    check_output("midstep_rst_count", {24'd0, cycle_count}, 32'd0);
    check_output("midstep_rst_cause", {30'd0, halt_cause}, 32'd0);
    rst = 1'b0;
    push_halt(CAUSE_CMD, 8'd40, 8'hA0);
    apply_stimulus(OP_RUN, '0, '0);
    repeat (39) @(negedge clk);
    apply_stimulus(OP_HALT, '0, '0);
    wait_halted(20);

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
